// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO: write address/strobe,
// registered Gray write pointer, and full/almost_full/count/overflow status in the write clock domain.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  input  logic                  clr_overflow,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int A     = ADDR_WIDTH;
  localparam int DEPTH = 2 ** A;
  localparam logic [A:0] AF_LEVEL = (A+1)'(DEPTH - ALMOST_FULL_THRESH);

  logic [A:0] wr_bin_reg;
  logic [A:0] wr_bin_next;
  logic [A:0] wr_gray_next;
  logic [A:0] rd_bin;
  logic [A:0] wr_count_next;
  logic [A:0] full_gray;
  logic       accept;
  logic       full_next;
  logic       almost_full_next;
  logic       overflow_next;

  // Gating with rst_n keeps the memory from being written while reset is held.
  assign accept  = wr_en & ~full & rst_n;
  assign mem_we  = accept;
  assign wr_addr = wr_bin_reg[A-1:0];

  assign wr_bin_next  = wr_bin_reg + (A+1)'(accept);
  assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);

  genvar gi;
  generate
    for (gi = 0; gi <= A; gi++) begin : g_rd_bin
      assign rd_bin[gi] = ^rd_ptr_gray_sync[A:gi];
    end
  endgenerate

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_gray        = {~rd_ptr_gray_sync[A:A-1], rd_ptr_gray_sync[A-2:0]};
  assign full_next        = (wr_gray_next == full_gray);
  assign wr_count_next    = wr_bin_next - rd_bin;
  assign almost_full_next = (wr_count_next >= AF_LEVEL);

  // A write attempt while full takes priority over a clear request.
  always_comb begin
    overflow_next = overflow;
    if (wr_en && full)
      overflow_next = 1'b1;
    else if (clr_overflow)
      overflow_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_reg  <= '0;
      wr_ptr_gray <= '0;
      wr_count    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_bin_reg  <= wr_bin_next;
      wr_ptr_gray <= wr_gray_next;
      wr_count    <= wr_count_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      overflow    <= overflow_next;
    end
  end

endmodule
